wake_decide: RTL and testbench
==============================

# wake_decide

Parametrised wake-decision stage that replaces the single-shot argmax/wake pair at the tail of the word-recognition pipeline. It accepts one signed score vector per utterance from the FC stage, computes the winning class with a configurable confidence margin, and requires a programmable number of consecutive target-class hits before asserting wake. After a wake it applies a frame-counted hold-off. Winning class indices are also forwarded on a streaming output for debug and host readback.

## Interface
Parameters:
- I_BW, 32, signed score width per class
- NUM_CLASSES, 2, classes per score vector (≥2)
- TARGET_CLASS, 1, class index that counts as a hit
- HIT_BW, 4, width of the consecutive-hit threshold and counter
- HOLD_BW, 8, width of the hold-off frame count

Ports (reset is synchronous and active-high, as already decided):
- clk_i  in  1  sole clock
- rst_i  in  1  synchronous active-high reset
- data_i  in  NUM_CLASSES*I_BW  score vector; class k at bits [k*I_BW +: I_BW]
- valid_i  in  1  input beat valid
- last_i  in  1  final beat of the stream
- ready_o  out  1  input accept
- cfg_hits_i  in  HIT_BW  consecutive hits required; 0 is treated as 1
- cfg_margin_i  in  I_BW  unsigned minimum (winner − runner-up)
- cfg_holdoff_i  in  HOLD_BW  frames ignored after a wake
- wake_clr_i  in  1  clears a sticky wake (see Configuration)
- class_o  out  $clog2(NUM_CLASSES)  winning class index
- class_valid_o  out  1  class_o valid
- class_last_o  out  1  echoes last_i of the beat
- class_ready_i  in  1  downstream accept for class_o
- wake_o  out  1  wake indication

## Operation
- Accept: beat accepted when valid_i && ready_o. ready_o = !class_valid_o || class_ready_i.
- Argmax: signed compare across all classes. On ties, the lowest index wins. The runner-up is the maximum over the remaining classes.
- Margin: diff = winner − runner-up, computed at I_BW+1 bits and always ≥0. The margin passes when diff ≥ {1'b0, cfg_margin_i}.
- Hit: winner == TARGET_CLASS and the margin passes.
- FSM states: ARMED, HOLDOFF.
- ARMED:
  - A hit increments hit_cnt, saturating at 2^HIT_BW−1.
  - A non-hit clears hit_cnt.
  - When the incremented hit_cnt ≥ max(cfg_hits_i, 1): fire wake, clear hit_cnt, load hold_cnt = cfg_holdoff_i.
  - If cfg_holdoff_i ≠ 0, go to HOLDOFF; otherwise stay in ARMED.
- HOLDOFF:
  - Each accepted beat decrements hold_cnt. Hits are not counted and hit_cnt stays 0.
  - When the beat brings hold_cnt to 0, go to ARMED. The next beat is evaluated normally.
- last_i:
  - After the beat has been evaluated (including a wake fire on that beat), hit_cnt clears.
  - FSM state and hold_cnt are unaffected.
- Config inputs are sampled on the accepting cycle. Changing them mid-stream takes effect on the next beat.

## Timing
- Reset values: ready_o=1, class_valid_o=0, class_o=0, class_last_o=0, wake_o=0. FSM=ARMED, hit_cnt=0, hold_cnt=0.
- Latency: a beat accepted at edge N drives class_o, class_valid_o and class_last_o from N+1. If it fires a wake, wake_o is high from N+1.
- Class output stall: class_valid_o holds with stable class_o until class_ready_i. Accept and drain in the same cycle sustain 1 beat/cycle.
- Wake pulse: exactly one cycle, independent of class_ready_i backpressure.
- Reset mid-operation: a reset during HOLDOFF or a stall discards the pending class beat and any hold-off, and returns to reset values on the next edge.

## Configuration
- Macro: WAKE_DECIDE_STICKY_EN.
- Defined: wake_o sets on a fire and stays high until a cycle with wake_clr_i=1. If clear and a new fire occur in the same cycle, the fire wins and wake_o stays 1.
- Undefined: wake_o is a 1-cycle pulse and wake_clr_i is ignored.

## Test plan
- Defaults (NUM_CLASSES=2, TARGET=1), cfg_hits=3, cfg_margin=10, cfg_holdoff=0; scores {c0=5, c1=20} ×3 with class_ready_i=1 → class_o=1 each beat, wake_o single pulse the cycle after beat 3.
- Margin fail: {c0=15, c1=20}, cfg_margin=10, ×5 → class_o=1, wake_o never asserts. Tie {c0=7, c1=7} → class_o=0.
- Miss resets the run: hit, hit, {c0=30, c1=0}, hit, hit, hit with cfg_hits=3 → exactly one wake, after the 6th beat.
- Hold-off: cfg_hits=1, cfg_holdoff=2, five hit beats → wakes after beats 1 and 4 only.
- Backpressure and last: class_ready_i=0 for 4 cycles → ready_o=0 and class_o stable. Beats hit, hit with last_i, hit (cfg_hits=3) → no wake.
- Sticky (WAKE_DECIDE_STICKY_EN): after a fire, wake_o holds for 10 cycles until wake_clr_i pulses → 0 the next cycle. rst_i during HOLDOFF → all outputs at reset values and the next hit beat counts.

Source files
------------

// File: rtl/wake_decide.sv
// wake_decide: argmax with confidence margin over a signed score vector,
// consecutive target-class hit counting, wake generation and frame-counted
// hold-off. Winning class indices are streamed out with valid/ready.
// Optional build macro: WAKE_DECIDE_STICKY_EN makes wake_o sticky until
// wake_clr_i; without it wake_o is a single-cycle pulse.
module wake_decide #(
    parameter int I_BW         = 32,
    parameter int NUM_CLASSES  = 2,
    parameter int TARGET_CLASS = 1,
    parameter int HIT_BW       = 4,
    parameter int HOLD_BW      = 8,
    localparam int CLS_W       = (NUM_CLASSES > 1) ? $clog2(NUM_CLASSES) : 1
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic [NUM_CLASSES*I_BW-1:0] data_i,
    input  logic                        valid_i,
    input  logic                        last_i,
    output logic                        ready_o,
    input  logic [HIT_BW-1:0]           cfg_hits_i,
    input  logic [I_BW-1:0]             cfg_margin_i,
    input  logic [HOLD_BW-1:0]          cfg_holdoff_i,
    input  logic                        wake_clr_i,
    output logic [CLS_W-1:0]            class_o,
    output logic                        class_valid_o,
    output logic                        class_last_o,
    input  logic                        class_ready_i,
    output logic                        wake_o
);

    typedef enum logic {
        ARMED   = 1'b0,
        HOLDOFF = 1'b1
    } state_t;

    state_t               state_q, state_d;
    logic [HIT_BW-1:0]    hit_cnt_q, hit_cnt_d;
    logic [HOLD_BW-1:0]   hold_cnt_q, hold_cnt_d;
    logic [CLS_W-1:0]     class_q, class_d;
    logic                 class_valid_q, class_valid_d;
    logic                 class_last_q, class_last_d;
    logic                 wake_q, wake_d;

    logic signed [I_BW-1:0] score [NUM_CLASSES];
    logic signed [I_BW-1:0] win_val;
    logic signed [I_BW-1:0] run_val;
    logic                   run_found;
    logic [CLS_W-1:0]       win_idx;
    logic [I_BW:0]          diff;
    logic                   margin_ok;
    logic                   beat_hit;
    logic                   accept;
    logic                   fire;
    logic [HIT_BW-1:0]      hit_thr;
    logic [HIT_BW-1:0]      hit_inc;

    // Unpack the flat score bus into one signed entry per class.
    always_comb begin
        for (int k = 0; k < NUM_CLASSES; k++) begin
            score[k] = data_i[k*I_BW +: I_BW];
        end
    end

    // Argmax (lowest index wins ties), runner-up over the other classes, margin test.
    always_comb begin
        win_idx   = '0;
        win_val   = score[0];
        for (int k = 1; k < NUM_CLASSES; k++) begin
            if (score[k] > win_val) begin
                win_val = score[k];
                win_idx = CLS_W'(k);
            end
        end
        run_val   = '0;
        run_found = 1'b0;
        for (int k = 0; k < NUM_CLASSES; k++) begin
            if ((CLS_W'(k) != win_idx) && (!run_found || (score[k] > run_val))) begin
                run_val   = score[k];
                run_found = 1'b1;
            end
        end
        diff      = {win_val[I_BW-1], win_val} - {run_val[I_BW-1], run_val};
        margin_ok = (diff >= {1'b0, cfg_margin_i});
        beat_hit  = (win_idx == CLS_W'(TARGET_CLASS)) && margin_ok;
    end

    assign ready_o = !class_valid_q || class_ready_i;
    assign accept  = valid_i && ready_o;
    assign hit_thr = (cfg_hits_i == '0) ? HIT_BW'(1) : cfg_hits_i;
    assign hit_inc = (hit_cnt_q == '1) ? hit_cnt_q : hit_cnt_q + HIT_BW'(1);

    // Hit counting, wake firing and hold-off sequencing per accepted beat.
    always_comb begin
        state_d    = state_q;
        hit_cnt_d  = hit_cnt_q;
        hold_cnt_d = hold_cnt_q;
        fire       = 1'b0;
        if (accept) begin
            case (state_q)
                ARMED: begin
                    if (beat_hit) begin
                        if (hit_inc >= hit_thr) begin
                            fire       = 1'b1;
                            hit_cnt_d  = '0;
                            hold_cnt_d = cfg_holdoff_i;
                            if (cfg_holdoff_i != '0) begin
                                state_d = HOLDOFF;
                            end
                        end else begin
                            hit_cnt_d = hit_inc;
                        end
                    end else begin
                        hit_cnt_d = '0;
                    end
                end
                HOLDOFF: begin
                    hit_cnt_d = '0;
                    if (hold_cnt_q <= HOLD_BW'(1)) begin
                        hold_cnt_d = '0;
                        state_d    = ARMED;
                    end else begin
                        hold_cnt_d = hold_cnt_q - HOLD_BW'(1);
                    end
                end
                default: begin
                    state_d = ARMED;
                end
            endcase
            if (last_i) begin
                hit_cnt_d = '0;
            end
        end
    end

    // Class output register: load on accept, drop valid once drained.
    always_comb begin
        class_d       = class_q;
        class_valid_d = class_valid_q;
        class_last_d  = class_last_q;
        if (accept) begin
            class_d       = win_idx;
            class_valid_d = 1'b1;
            class_last_d  = last_i;
        end else if (class_ready_i) begin
            class_valid_d = 1'b0;
        end
    end

`ifdef WAKE_DECIDE_STICKY_EN
    // Sticky wake: a new fire beats a simultaneous clear.
    always_comb begin
        wake_d = fire || (wake_q && !wake_clr_i);
    end
`else
    logic unused_wake_clr;
    assign unused_wake_clr = wake_clr_i;

    // Pulsed wake: high only in the cycle after the firing beat.
    always_comb begin
        wake_d = fire;
    end
`endif

    // State registers with synchronous active-high reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q       <= ARMED;
            hit_cnt_q     <= '0;
            hold_cnt_q    <= '0;
            class_q       <= '0;
            class_valid_q <= 1'b0;
            class_last_q  <= 1'b0;
            wake_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            hit_cnt_q     <= hit_cnt_d;
            hold_cnt_q    <= hold_cnt_d;
            class_q       <= class_d;
            class_valid_q <= class_valid_d;
            class_last_q  <= class_last_d;
            wake_q        <= wake_d;
        end
    end

    assign class_o       = class_q;
    assign class_valid_o = class_valid_q;
    assign class_last_o  = class_last_q;
    assign wake_o        = wake_q;

endmodule

// File: tb/tb_wake_decide.sv
// Testbench for wake_decide: directed scenarios plus randomized beats,
// scored against a behavioural model through an expected-beat queue.
`timescale 1ns/1ps
module tb_wake_decide;

    localparam int I_BW         = 32;
    localparam int NUM_CLASSES  = 2;
    localparam int TARGET_CLASS = 1;
    localparam int HIT_BW       = 4;
    localparam int HOLD_BW      = 8;

    logic                        clk_i = 1'b0;
    logic                        rst_i = 1'b1;
    logic [NUM_CLASSES*I_BW-1:0] data_i = '0;
    logic                        valid_i = 1'b0;
    logic                        last_i = 1'b0;
    logic                        ready_o;
    logic [HIT_BW-1:0]           cfg_hits_i = '0;
    logic [I_BW-1:0]             cfg_margin_i = '0;
    logic [HOLD_BW-1:0]          cfg_holdoff_i = '0;
    logic                        wake_clr_i = 1'b0;
    logic [0:0]                  class_o;
    logic                        class_valid_o;
    logic                        class_last_o;
    logic                        class_ready_i = 1'b1;
    logic                        wake_o;

    wake_decide #(
        .I_BW(I_BW), .NUM_CLASSES(NUM_CLASSES), .TARGET_CLASS(TARGET_CLASS),
        .HIT_BW(HIT_BW), .HOLD_BW(HOLD_BW)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i), .data_i(data_i), .valid_i(valid_i),
        .last_i(last_i), .ready_o(ready_o), .cfg_hits_i(cfg_hits_i),
        .cfg_margin_i(cfg_margin_i), .cfg_holdoff_i(cfg_holdoff_i),
        .wake_clr_i(wake_clr_i), .class_o(class_o), .class_valid_o(class_valid_o),
        .class_last_o(class_last_o), .class_ready_i(class_ready_i), .wake_o(wake_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        int cls;
        bit last;
    } exp_t;

    exp_t expQ[$];
    int   checks = 0;
    int   fails = 0;
    bit   running = 0;
    int   readyMode = 0;
    bit   clrRandom = 0;
    bit   pendFire = 0;
    bit   wakeExp = 0;
    bit   stallPrev = 0;
    int   mRun = 0;
    int   mHold = 0;

    task automatic checkOutput(input string name, input longint actual, input longint expected);
        checks++;
        if (actual != expected) begin
            fails++;
            $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // Behavioural model of one accepted beat: argmax, margin, run length, hold-off.
    task automatic modelAccept(input longint c0, input longint c1, input bit last);
        longint sc[2];
        int     win = 0;
        longint best;
        longint runner = 0;
        bit     found = 0;
        bit     hit;
        int     thr;
        exp_t   e;
        sc[0] = c0;
        sc[1] = c1;
        best = sc[0];
        for (int k = 1; k < NUM_CLASSES; k++) begin
            if (sc[k] > best) begin
                best = sc[k];
                win = k;
            end
        end
        for (int k = 0; k < NUM_CLASSES; k++) begin
            if (k != win && (!found || sc[k] > runner)) begin
                runner = sc[k];
                found = 1;
            end
        end
        hit = (win == TARGET_CLASS) && ((best - runner) >= longint'(cfg_margin_i));
        thr = (cfg_hits_i == 0) ? 1 : int'(cfg_hits_i);
        if (mHold > 0) begin
            mHold--;
            mRun = 0;
        end else if (hit) begin
            mRun = (mRun + 1 > 15) ? 15 : mRun + 1;
            if (mRun >= thr) begin
                pendFire = 1;
                mRun = 0;
                mHold = int'(cfg_holdoff_i);
            end
        end else begin
            mRun = 0;
        end
        if (last) mRun = 0;
        e.cls = win;
        e.last = last;
        expQ.push_back(e);
    endtask

    // Present one beat and hold it until the DUT accepts it (bounded wait).
    task automatic applyStimulus(input logic signed [31:0] c0, input logic signed [31:0] c1, input bit last);
        int cycles = 0;
        bit done = 0;
        data_i = {c1, c0};
        valid_i = 1'b1;
        last_i = last;
        while (!done) begin
            @(negedge clk_i);
            if (ready_o) begin
                modelAccept(longint'(c0), longint'(c1), last);
                done = 1;
            end
            @(posedge clk_i);
            #1;
            cycles++;
            if (!done && cycles > 200) begin
                checkOutput("accept_timeout", 0, 1);
                done = 1;
            end
        end
        valid_i = 1'b0;
        last_i = 1'b0;
    endtask

    task automatic doReset();
        rst_i = 1'b1;
        expQ.delete();
        mRun = 0;
        mHold = 0;
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;
    endtask

    task automatic setCfg(input int hits, input longint margin, input int holdoff);
        cfg_hits_i = HIT_BW'(hits);
        cfg_margin_i = I_BW'(margin);
        cfg_holdoff_i = HOLD_BW'(holdoff);
    endtask

    // Expected wake for the current cycle, advanced at each clock edge.
    always @(posedge clk_i) begin
        if (rst_i) begin
            wakeExp = 0;
        end else begin
`ifdef WAKE_DECIDE_STICKY_EN
            wakeExp = pendFire || (wakeExp && !wake_clr_i);
`else
            wakeExp = pendFire;
`endif
        end
        pendFire = 0;
    end

    // Downstream ready and wake clear generation.
    always @(posedge clk_i) begin
        #1;
        case (readyMode)
            0: class_ready_i = 1'b1;
            1: class_ready_i = ($urandom_range(0, 3) != 0);
            default: class_ready_i = 1'b0;
        endcase
        wake_clr_i = clrRandom ? ($urandom_range(0, 7) == 0) : 1'b0;
    end

    // Monitor: wake every cycle, class beats as they are consumed.
    always @(negedge clk_i) begin
        exp_t e;
        if (running && !rst_i) begin
            checkOutput("wake_o", longint'(wake_o), longint'(wakeExp));
            if (stallPrev) checkOutput("stall_valid", longint'(class_valid_o), 1);
            if (class_valid_o && class_ready_i) begin
                if (expQ.size() == 0) begin
                    checkOutput("unexpected_beat", 1, 0);
                end else begin
                    e = expQ.pop_front();
                    checkOutput("class_o", longint'(class_o), longint'(e.cls));
                    checkOutput("class_last_o", longint'(class_last_o), longint'(e.last));
                end
            end
            stallPrev = class_valid_o && !class_ready_i;
        end else begin
            stallPrev = 0;
        end
    end

    initial begin
        logic signed [31:0] c0, c1;
        longint marginSel[4];
        marginSel[0] = 0;
        marginSel[1] = 5;
        marginSel[2] = 10;
        marginSel[3] = 64'hFFFF_FFFF;

        @(posedge clk_i);
        #1;
        doReset();
        @(negedge clk_i);
        checkOutput("rst_ready", longint'(ready_o), 1);
        checkOutput("rst_class_valid", longint'(class_valid_o), 0);
        checkOutput("rst_class", longint'(class_o), 0);
        checkOutput("rst_class_last", longint'(class_last_o), 0);
        checkOutput("rst_wake", longint'(wake_o), 0);
        @(posedge clk_i);
        #1;
        running = 1;

        // Three qualifying hits fire one wake.
        setCfg(3, 10, 0);
        repeat (3) applyStimulus(5, 20, 0);
        @(negedge clk_i);
        checkOutput("tp_wake_after_3", longint'(wake_o), 1);
        @(posedge clk_i);
        #1;

        // Margin failures, a tie, then an exact-margin hit.
        repeat (5) applyStimulus(15, 20, 0);
        applyStimulus(7, 7, 0);
        applyStimulus(10, 20, 0);
        applyStimulus(30, 0, 0);

        // A miss restarts the run.
        applyStimulus(5, 20, 0);
        applyStimulus(5, 20, 0);
        applyStimulus(30, 0, 0);
        repeat (3) applyStimulus(5, 20, 0);

        // Hold-off: wakes on beats 1 and 4 of five.
        setCfg(1, 10, 2);
        repeat (5) applyStimulus(5, 20, 0);

        // Reset while in hold-off, then a single hit must fire.
        doReset();
        @(negedge clk_i);
        checkOutput("rst2_class_valid", longint'(class_valid_o), 0);
        checkOutput("rst2_wake", longint'(wake_o), 0);
        @(posedge clk_i);
        #1;
        setCfg(1, 10, 0);
        applyStimulus(5, 20, 0);
        @(negedge clk_i);
        checkOutput("post_rst_wake", longint'(wake_o), 1);
        @(posedge clk_i);
        #1;

        // Backpressure and last clearing the run.
        setCfg(3, 10, 0);
        @(negedge clk_i);
        readyMode = 2;
        @(posedge clk_i);
        #1;
        applyStimulus(5, 20, 0);
        data_i = {32'sd20, 32'sd5};
        valid_i = 1'b1;
        last_i = 1'b1;
        repeat (4) begin
            @(negedge clk_i);
            checkOutput("bp_ready", longint'(ready_o), 0);
            checkOutput("bp_class", longint'(class_o), 1);
        end
        readyMode = 0;
        @(posedge clk_i);
        #1;
        applyStimulus(5, 20, 1);
        applyStimulus(5, 20, 0);

        // Randomized traffic with random backpressure, config and resets.
        @(negedge clk_i);
        readyMode = 1;
        clrRandom = 1;
        @(posedge clk_i);
        #1;
        for (int i = 0; i < 400; i++) begin
            if (i % 20 == 0) begin
                setCfg($urandom_range(0, 4), marginSel[$urandom_range(0, 3)], $urandom_range(0, 3));
            end
            if ($urandom_range(0, 99) == 0) doReset();
            case ($urandom_range(0, 5))
                0: begin c0 = $urandom; c1 = $urandom; end
                1: begin c0 = 32'sh8000_0000; c1 = 32'sh7FFF_FFFF; end
                2: begin c0 = $urandom_range(0, 40); c1 = c0; end
                default: begin c0 = $urandom_range(0, 50); c1 = $urandom_range(0, 80); end
            endcase
            applyStimulus(c0, c1, ($urandom_range(0, 7) == 0));
        end

        // Drain the class stream.
        @(negedge clk_i);
        readyMode = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk_i);
            if (expQ.size() == 0) break;
        end
        checkOutput("drain_left", longint'(expQ.size()), 0);
        @(posedge clk_i);
        #1;
        running = 0;
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
